ins_dispatch: RTL and testbench

// - Parametrised instruction dispatcher and cross-unit synchroniser. Successor to the fixed 3-way split in top_control.
// - Routes one instruction stream to UNIT_NUM engines (default ddr2pe, pe_array, pe2ddr) through per-unit FIFOs.
// - Enforces producer/consumer order on a BUF_SETS-deep ring of ping-pong buffer sets using token counters.
// - Drives per-unit buffer-set select and the global working flag.

---
 rtl/ins_dispatch_pkg.sv | 15 +
 rtl/ins_fifo.sv | 39 +++
 rtl/ins_dispatch.sv | 93 +++++++++
 tb/tb_ins_dispatch.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_dispatch_pkg.sv
// ins_dispatch_pkg: shared instruction widths, header layout and engine ids for the dispatcher.
package ins_dispatch_pkg;
    localparam int INST_W = 32;
    localparam int UNIT_ID_W = 3;
    localparam int HDR_WAIT_BIT = INST_W - UNIT_ID_W - 1;
    localparam int HDR_SIGNAL_BIT = INST_W - UNIT_ID_W - 2;
    typedef enum logic [UNIT_ID_W-1:0] {
        UNIT_DDR2PE = 3'd0,
        UNIT_PE     = 3'd1,
        UNIT_PE2DDR = 3'd2
    } unit_e;
    function automatic int bw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ins_fifo.sv
// ins_fifo: show-ahead circular buffer; the extra pointer MSB separates full from empty.
module ins_fifo import ins_dispatch_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             ne_d
);
    localparam int AW = bw(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    always_comb begin
        wr_d = wr_q + {{AW{1'b0}}, push};
        rd_d = rd_q + {{AW{1'b0}}, pop};
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= din;
    end
    assign head  = mem_q[rd_q[AW-1:0]];
    assign empty = wr_q == rd_q;
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign ne_d  = wr_d != rd_d;
endmodule

// File: rtl/ins_dispatch.sv
// ins_dispatch: routes one instruction stream to per-engine FIFOs and orders engines
// around a ring of buffer sets with token counters.
module ins_dispatch #(
    parameter int INST_W     = ins_dispatch_pkg::INST_W,
    parameter int UNIT_NUM   = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int BUF_SETS   = 2
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   ins_valid,
    output logic                                                   ins_ready,
    input  logic [INST_W-1:0]                                      ins,
    output logic [UNIT_NUM-1:0]                                    unit_valid,
    input  logic [UNIT_NUM-1:0]                                    unit_ready,
    output logic [UNIT_NUM-1:0][INST_W-1:0]                        unit_ins,
    input  logic [UNIT_NUM-1:0]                                    unit_done,
    output logic [UNIT_NUM-1:0][ins_dispatch_pkg::bw(BUF_SETS)-1:0] buf_sel,
    output logic                                                   working,
    output logic                                                   err
);
    import ins_dispatch_pkg::*;
    localparam int SW = bw(BUF_SETS);
    localparam int TW = bw(BUF_SETS + 1);
    localparam int WAIT_B = INST_W - UNIT_ID_W - 1;
    localparam int SIG_B = INST_W - UNIT_ID_W - 2;

    logic [UNIT_ID_W-1:0] id;
    logic id_ok;
    logic [UNIT_NUM-1:0] full, empty, ne_d, push, pop, head_wait, done_ok, inc, dec, tok_ovf;
    logic [UNIT_NUM-1:0] busy_q, busy_d, sig_q, sig_d;
    logic [UNIT_NUM-1:0][TW-1:0] tok_q, tok_d;
    logic [UNIT_NUM-1:0][SW-1:0] sel_q, sel_d;
    logic working_q, working_d, err_q, err_d;

    assign id = ins[INST_W-1 -: UNIT_ID_W];
    assign id_ok = int'(id) < UNIT_NUM;

    for (genvar k = 0; k < UNIT_NUM; k++) begin : g_unit
        ins_fifo #(.WIDTH(INST_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk(clk), .rst(rst), .push(push[k]), .din(ins), .pop(pop[k]),
            .head(unit_ins[k]), .full(full[k]), .empty(empty[k]), .ne_d(ne_d[k])
        );
    end

    always_comb begin
        ins_ready = !id_ok;
        for (int k = 0; k < UNIT_NUM; k++) if (int'(id) == k) ins_ready = !full[k];
        for (int k = 0; k < UNIT_NUM; k++) begin
            push[k] = ins_valid & ins_ready & (int'(id) == k);
            head_wait[k] = unit_ins[k][WAIT_B];
            unit_valid[k] = !empty[k] & !busy_q[k] & (!head_wait[k] | (tok_q[k] != '0));
            pop[k] = unit_valid[k] & unit_ready[k];
            done_ok[k] = unit_done[k] & busy_q[k];
            busy_d[k] = pop[k] | (busy_q[k] & !done_ok[k]);
            sig_d[k] = pop[k] ? unit_ins[k][SIG_B] : sig_q[k];
            sel_d[k] = (pop[k] & head_wait[k]) ?
                       ((sel_q[k] == SW'(BUF_SETS - 1)) ? '0 : sel_q[k] + 1'b1) : sel_q[k];
        end
        // a signalling completion on unit k-1 hands one buffer set to unit k
        for (int k = 0; k < UNIT_NUM; k++) begin
            inc[k] = done_ok[(k + UNIT_NUM - 1) % UNIT_NUM] & sig_q[(k + UNIT_NUM - 1) % UNIT_NUM];
            dec[k] = pop[k] & head_wait[k];
            tok_ovf[k] = inc[k] & !dec[k] & (tok_q[k] == TW'(BUF_SETS));
            tok_d[k] = (inc[k] == dec[k] || tok_ovf[k]) ? tok_q[k] :
                       inc[k] ? tok_q[k] + 1'b1 : tok_q[k] - 1'b1;
        end
        err_d = err_q | (ins_valid & ins_ready & !id_ok) | (|(unit_done & ~busy_q)) | (|tok_ovf);
        working_d = (|ne_d) | (|busy_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            sig_q <= '0;
            sel_q <= '0;
            working_q <= 1'b0;
            err_q <= 1'b0;
            for (int k = 0; k < UNIT_NUM; k++) tok_q[k] <= (k == 0) ? TW'(BUF_SETS) : '0;
        end else begin
            busy_q <= busy_d;
            sig_q <= sig_d;
            sel_q <= sel_d;
            working_q <= working_d;
            err_q <= err_d;
            tok_q <= tok_d;
        end
    end

    assign buf_sel = sel_q;
    assign working = working_q;
    assign err = err_q;
endmodule

// File: tb/tb_ins_dispatch.sv
// tb_ins_dispatch: directed scenarios for the dispatcher with hand-derived cycle expectations.
module tb_ins_dispatch;
    import ins_dispatch_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ins_valid = 1'b0;
    logic ins_ready;
    logic [INST_W-1:0] ins = '0;
    logic [2:0] unit_valid;
    logic [2:0] unit_ready = 3'b111;
    logic [2:0][INST_W-1:0] unit_ins;
    logic [2:0] unit_done = 3'b000;
    logic [2:0][0:0] buf_sel;
    logic working, err;
    int checks = 0;
    int errors = 0;
    int fw[3][4];
    int bs[3][4];
    int nf[3];
    logic [INST_W-1:0] pq[$];

    always #5 clk = ~clk;

    ins_dispatch #(.INST_W(INST_W), .UNIT_NUM(3), .FIFO_DEPTH(4), .BUF_SETS(2)) dut (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
        .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_ins(unit_ins),
        .unit_done(unit_done), .buf_sel(buf_sel), .working(working), .err(err)
    );

    function automatic logic [INST_W-1:0] mk(input logic [2:0] id, input logic w, input logic s,
                                             input logic [7:0] tag);
        mk = '0;
        mk[INST_W-1 -: 3] = id;
        mk[HDR_WAIT_BIT] = w;
        mk[HDR_SIGNAL_BIT] = s;
        mk[7:0] = tag;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        ins_valid = 1'b0;
        ins = '0;
        unit_done = '0;
        unit_ready = 3'b111;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        tick();
    endtask

    // Feeds pq one word per accepted cycle; completes every issued unit 3 cycles after issue.
    task automatic run(input int nw);
        int cd[3];
        logic [2:0] fired;
        logic acc;
        for (int k = 0; k < 3; k++) begin
            cd[k] = 0;
            nf[k] = 0;
            for (int n = 0; n < 4; n++) begin
                fw[k][n] = -1;
                bs[k][n] = -1;
            end
        end
        for (int w = 0; w < nw; w++) begin
            ins_valid = pq.size() > 0;
            ins = ins_valid ? pq[0] : '0;
            for (int k = 0; k < 3; k++) unit_done[k] = cd[k] == 1;
            #1;
            fired = unit_valid & unit_ready;
            acc = ins_valid && ins_ready;
            for (int k = 0; k < 3; k++) if (fired[k]) begin
                if (nf[k] < 4) begin
                    fw[k][nf[k]] = w;
                    bs[k][nf[k]] = int'(buf_sel[k]);
                end
                nf[k]++;
            end
            tick();
            if (acc) void'(pq.pop_front());
            for (int k = 0; k < 3; k++) begin
                if (cd[k] > 0) cd[k]--;
                if (fired[k]) cd[k] = 3;
            end
        end
        ins_valid = 1'b0;
        ins = '0;
        unit_done = '0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (unit_valid !== 3'b000) begin errors++; $display("FAIL reset_unit_valid got %b exp 000", unit_valid); end
        checks++; if (ins_ready !== 1'b1) begin errors++; $display("FAIL reset_ins_ready got %b exp 1", ins_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (working !== 1'b0) begin errors++; $display("FAIL reset_working got %b exp 0", working); end
        checks++; if (buf_sel !== 3'b000) begin errors++; $display("FAIL reset_buf_sel got %b exp 000", buf_sel); end
    endtask

    task automatic test_pipeline();
        apply_reset();
        pq = '{mk(0, 1, 1, 8'h01), mk(1, 1, 1, 8'h02), mk(2, 1, 1, 8'h03), mk(0, 1, 1, 8'h04)};
        run(16);
        checks++; if (fw[0][0] !== 1) begin errors++; $display("FAIL pipe_d2p1_cycle got %0d exp 1", fw[0][0]); end
        checks++; if (fw[1][0] !== 5) begin errors++; $display("FAIL pipe_pe_cycle got %0d exp 5", fw[1][0]); end
        checks++; if (fw[0][1] !== 5) begin errors++; $display("FAIL pipe_d2p2_cycle got %0d exp 5", fw[0][1]); end
        checks++; if (fw[2][0] !== 9) begin errors++; $display("FAIL pipe_p2d_cycle got %0d exp 9", fw[2][0]); end
        checks++; if (bs[0][1] !== 1) begin errors++; $display("FAIL pipe_d2p2_buf_sel got %0d exp 1", bs[0][1]); end
        checks++; if (nf[0] + nf[1] + nf[2] !== 4) begin errors++; $display("FAIL pipe_issue_count got %0d exp 4", nf[0] + nf[1] + nf[2]); end
        #1;
        checks++; if (buf_sel !== 3'b110) begin errors++; $display("FAIL pipe_final_buf_sel got %b exp 110", buf_sel); end
        checks++; if (working !== 1'b0) begin errors++; $display("FAIL pipe_final_working got %b exp 0", working); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL pipe_err got %b exp 0", err); end
    endtask

    task automatic test_starvation();
        apply_reset();
        pq = '{mk(0, 1, 1, 8'h11), mk(0, 1, 1, 8'h12), mk(0, 1, 1, 8'h13)};
        run(12);
        checks++; if (nf[0] !== 2) begin errors++; $display("FAIL starve_d2p_count got %0d exp 2", nf[0]); end
        #1;
        checks++; if (unit_valid[0] !== 1'b0) begin errors++; $display("FAIL starve_stalled got %b exp 0", unit_valid[0]); end
        checks++; if (working !== 1'b1) begin errors++; $display("FAIL starve_working got %b exp 1", working); end
        pq = '{mk(1, 1, 1, 8'h14), mk(2, 1, 1, 8'h15)};
        run(14);
        checks++; if (fw[1][0] !== 1) begin errors++; $display("FAIL starve_pe_cycle got %0d exp 1", fw[1][0]); end
        checks++; if (fw[2][0] !== 5) begin errors++; $display("FAIL starve_p2d_cycle got %0d exp 5", fw[2][0]); end
        checks++; if (fw[0][0] !== 9) begin errors++; $display("FAIL starve_d2p3_cycle got %0d exp 9", fw[0][0]); end
        checks++; if (bs[0][0] !== 0) begin errors++; $display("FAIL starve_d2p3_buf_sel got %0d exp 0", bs[0][0]); end
    endtask

    task automatic test_back_pressure();
        apply_reset();
        ins_valid = 1'b1;
        ins = mk(1, 0, 0, 8'h40);
        tick();
        ins = mk(1, 0, 0, 8'h41);
        #1;
        checks++; if (unit_valid[1] !== 1'b1) begin errors++; $display("FAIL bp_first_issue got %b exp 1", unit_valid[1]); end
        tick();
        for (int i = 2; i <= 4; i++) begin
            ins = mk(1, 0, 0, 8'(8'h40 + i));
            tick();
        end
        ins = mk(1, 0, 0, 8'h45);
        #1;
        checks++; if (ins_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", ins_ready); end
        checks++; if (unit_valid[1] !== 1'b0) begin errors++; $display("FAIL bp_busy_valid got %b exp 0", unit_valid[1]); end
        unit_done[1] = 1'b1;
        tick();
        unit_done[1] = 1'b0;
        #1;
        checks++; if (ins_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_before_pop got %b exp 0", ins_ready); end
        checks++; if (unit_ins[1] !== mk(1, 0, 0, 8'h41)) begin errors++; $display("FAIL bp_head got %h exp %h", unit_ins[1], mk(1, 0, 0, 8'h41)); end
        tick();
        #1;
        checks++; if (ins_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %b exp 1", ins_ready); end
        tick();
        ins_valid = 1'b0;
        unit_done[1] = 1'b1;
        tick();
        unit_done[1] = 1'b0;
        #1;
        checks++; if (unit_ins[1] !== mk(1, 0, 0, 8'h42)) begin errors++; $display("FAIL bp_order got %h exp %h", unit_ins[1], mk(1, 0, 0, 8'h42)); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bp_err got %b exp 0", err); end
    endtask

    task automatic test_bypass();
        apply_reset();
        ins_valid = 1'b1;
        ins = mk(1, 0, 0, 8'h50);
        tick();
        ins_valid = 1'b0;
        #1;
        checks++; if (unit_valid[1] !== 1'b1) begin errors++; $display("FAIL byp_issue got %b exp 1", unit_valid[1]); end
        checks++; if (unit_ins[1] !== mk(1, 0, 0, 8'h50)) begin errors++; $display("FAIL byp_word got %h exp %h", unit_ins[1], mk(1, 0, 0, 8'h50)); end
        tick();
        #1;
        checks++; if (buf_sel[1] !== 1'b0) begin errors++; $display("FAIL byp_buf_sel got %b exp 0", buf_sel[1]); end
        unit_done[1] = 1'b1;
        ins_valid = 1'b1;
        ins = mk(1, 1, 0, 8'h51);
        tick();
        unit_done[1] = 1'b0;
        ins_valid = 1'b0;
        #1;
        checks++; if (unit_valid[1] !== 1'b0) begin errors++; $display("FAIL byp_wait_no_token got %b exp 0", unit_valid[1]); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL byp_err got %b exp 0", err); end
    endtask

    task automatic test_errors();
        apply_reset();
        ins_valid = 1'b1;
        ins = mk(7, 1, 1, 8'h60);
        #1;
        checks++; if (ins_ready !== 1'b1) begin errors++; $display("FAIL err_id7_ready got %b exp 1", ins_ready); end
        tick();
        ins_valid = 1'b0;
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_id7 got %b exp 1", err); end
        tick();
        checks++; if (working !== 1'b0 || unit_valid !== 3'b000) begin errors++; $display("FAIL err_id7_dropped got %b/%b exp 0/000", working, unit_valid); end
        apply_reset();
        unit_done = 3'b100;
        tick();
        unit_done = 3'b000;
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_spurious_done got %b exp 1", err); end
        apply_reset();
        pq = '{mk(2, 0, 1, 8'h61)};
        run(6);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_tok_overflow got %b exp 1", err); end
        pq = '{mk(0, 1, 0, 8'h62), mk(0, 1, 0, 8'h63), mk(0, 1, 0, 8'h64)};
        run(14);
        checks++; if (nf[0] !== 2) begin errors++; $display("FAIL err_tok_saturated got %0d exp 2", nf[0]); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        ins_valid = 1'b1;
        ins = mk(0, 1, 1, 8'h31);
        tick();
        ins = mk(0, 1, 1, 8'h32);
        tick();
        ins = mk(7, 0, 0, 8'h00);
        tick();
        ins_valid = 1'b0;
        ins = '0;
        #1;
        checks++; if (working !== 1'b1 || err !== 1'b1 || buf_sel[0] !== 1'b1) begin errors++; $display("FAIL ar_pre got w%b e%b s%b exp 111", working, err, buf_sel[0]); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (unit_valid !== 3'b000) begin errors++; $display("FAIL ar_unit_valid got %b exp 000", unit_valid); end
        checks++; if (buf_sel !== 3'b000) begin errors++; $display("FAIL ar_buf_sel got %b exp 000", buf_sel); end
        checks++; if (working !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL ar_flags got w%b e%b exp 00", working, err); end
        @(negedge clk) rst = 1'b1;
        tick();
        ins_valid = 1'b1;
        ins = mk(0, 1, 0, 8'h33);
        tick();
        ins_valid = 1'b0;
        #1;
        checks++; if (unit_valid[0] !== 1'b1 || buf_sel[0] !== 1'b0) begin errors++; $display("FAIL ar_first_issue got v%b s%b exp v1 s0", unit_valid[0], buf_sel[0]); end
        tick();
        #1;
        checks++; if (buf_sel[0] !== 1'b1) begin errors++; $display("FAIL ar_buf_sel_adv got %b exp 1", buf_sel[0]); end
        unit_done[1] = 1'b1;
        tick();
        unit_done[1] = 1'b0;
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ar_stale_done got %b exp 1", err); end
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_starvation();
        test_back_pressure();
        test_bypass();
        test_errors();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
